// File: rtl/com_bus_arbiter_if.sv
// com_bus_arbiter_if: common-bus request/grant bundle between requesters and the arbiter.
//   Requests: Com_Bus_Req_proc[7:0] (0-3 DL cores, 4-7 IL cores), Com_Bus_Req_snoop[3:0], Mem_snoop_req.
//   Grants:   Com_Bus_Gnt_proc[7:0], Com_Bus_Gnt_snoop[3:0], Mem_snoop_gnt, plus Bus_busy and Gnt_timeout.
//   master = requester side, slave = arbiter side.
interface com_bus_arbiter_if;
    logic [7:0] Com_Bus_Req_proc;
    logic [3:0] Com_Bus_Req_snoop;
    logic       Mem_snoop_req;
    logic [7:0] Com_Bus_Gnt_proc;
    logic [3:0] Com_Bus_Gnt_snoop;
    logic       Mem_snoop_gnt;
    logic       Bus_busy;
    logic       Gnt_timeout;
    modport master (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Gnt_timeout
    );
    modport slave (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Gnt_timeout
    );
endinterface

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: common-bus arbiter, memory > snoop (fixed, lowest index) > proc (round-robin), non-preemptive.
//   clk  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : com_bus_arbiter_if.slave (requests in, registered grants/Bus_busy/Gnt_timeout out)
module com_bus_arbiter (
    input  logic              clk,
    input  logic              RST,
    com_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_SNOOP, GNT_PROC} state_t;
    state_t     state_q;
    logic [2:0] rr_ptr_q;
    logic [2:0] idx_q;
    logic [7:0] gnt_proc_q;
    logic [3:0] gnt_snoop_q;
    logic       gnt_mem_q;
    logic       busy_q;
    logic       timeout_q;
    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;
    logic [1:0] snoop_idx;
    logic [2:0] proc_idx;
    logic       hold_req;
    // Scan downwards so the lowest index (snoop) / nearest offset from rr_ptr (proc) is assigned last and wins.
    always_comb begin
        snoop_idx = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (bus.Com_Bus_Req_snoop[k]) snoop_idx = 2'(k);
        proc_idx = rr_ptr_q;
        for (int k = 7; k >= 0; k--)
            if (bus.Com_Bus_Req_proc[3'(rr_ptr_q + 3'(k))]) proc_idx = 3'(rr_ptr_q + 3'(k));
        hold_req = state_q == GNT_MEM   ? bus.Mem_snoop_req :
                   state_q == GNT_SNOOP ? bus.Com_Bus_Req_snoop[idx_q[1:0]] :
                   state_q == GNT_PROC  ? bus.Com_Bus_Req_proc[idx_q] : 1'b0;
        hold_cnt_d = hold_cnt_q + 8'(hold_cnt_q != 8'hff);
    end
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_mem_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else if (state_q == IDLE) begin
            hold_cnt_q <= '0;
            if (bus.Mem_snoop_req) begin
                state_q   <= GNT_MEM;
                gnt_mem_q <= 1'b1;
                busy_q    <= 1'b1;
            end else if (|bus.Com_Bus_Req_snoop) begin
                state_q     <= GNT_SNOOP;
                idx_q       <= {1'b0, snoop_idx};
                gnt_snoop_q <= 4'b0001 << snoop_idx;
                busy_q      <= 1'b1;
            end else if (|bus.Com_Bus_Req_proc) begin
                state_q    <= GNT_PROC;
                idx_q      <= proc_idx;
                gnt_proc_q <= 8'b0000_0001 << proc_idx;
                rr_ptr_q   <= proc_idx + 3'd1;
                busy_q     <= 1'b1;
            end
        end else if (hold_req) begin
            hold_cnt_q <= hold_cnt_d;
            // hold_cnt reaches 255 on this edge when it was 254; sticky until reset
            timeout_q  <= timeout_q | (hold_cnt_q >= 8'd254);
        end else begin
            state_q     <= IDLE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_mem_q   <= 1'b0;
            busy_q      <= 1'b0;
        end
    end
    assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign bus.Mem_snoop_gnt     = gnt_mem_q;
    assign bus.Bus_busy          = busy_q;
    assign bus.Gnt_timeout       = timeout_q;
endmodule
